// File: rtl/ram_burst_pkg.sv
// Shared sizing defaults and FSM encoding
// for the burst RAM master.
package ram_burst_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;
endpackage

// File: rtl/ram_burst_master_if.sv
// Command, write-beat and read-beat channels
// between a client (master) and the burst engine (slave).
interface ram_burst_master_if #(
    parameter int ADDR_W = ram_burst_pkg::ADDR_W,
    parameter int DATA_W = ram_burst_pkg::DATA_W,
    parameter int LEN_W  = ram_burst_pkg::LEN_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        input  cmd_ready, wr_ready,
        input  rd_valid, rd_data, rd_last
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        output cmd_ready, wr_ready,
        output rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/ram_burst_addr_gen.sv
// Burst address and beats-remaining tracker;
// the address wraps naturally at its width.
module ram_burst_addr_gen #(
    parameter int ADDR_W = ram_burst_pkg::ADDR_W,
    parameter int LEN_W  = ram_burst_pkg::LEN_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  cnt_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    // Load a new burst or advance one beat.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = addr_i;
            cnt_d  = cnt_i;
        end else if (step_i) begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - LEN_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == '0);
endmodule

// File: rtl/ram_burst_master.sv
// Burst engine turning write/read commands into
// registered single-port RAM accesses.
module ram_burst_master #(
    parameter int ADDR_W = ram_burst_pkg::ADDR_W,
    parameter int DATA_W = ram_burst_pkg::DATA_W,
    parameter int LEN_W  = ram_burst_pkg::LEN_W
) (
    input  logic              clock,
    input  logic              reset_n,
    ram_burst_master_if.slave bus,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_out
);
    import ram_burst_pkg::*;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_in_q, ram_in_d;
    logic              ram_write_q, ram_write_d;

    logic iss_q, iss_d;
    logic iss_last_q, iss_last_d;
    logic s1_q, s1_last_q;
    logic rd_valid_q, rd_last_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              ld, step, g_last;
    logic [ADDR_W-1:0] ld_addr, g_addr;
    logic [LEN_W-1:0]  ld_cnt;
    logic              cmd_acc, wr_acc;

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.wr_ready  = (state_q == WRITE);
    assign busy          = (state_q != IDLE);
    assign cmd_acc       = bus.cmd_valid && bus.cmd_ready;
    assign wr_acc        = bus.wr_valid && bus.wr_ready;

    ram_burst_addr_gen #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) u_addr_gen (
        .clock  (clock),
        .reset_n(reset_n),
        .load_i (ld),
        .addr_i (ld_addr),
        .cnt_i  (ld_cnt),
        .step_i (step),
        .addr_o (g_addr),
        .last_o (g_last)
    );

    // Next state and RAM request. A read issues its first
    // address at acceptance, so the generator starts one ahead.
    always_comb begin
        state_d       = state_q;
        ld            = 1'b0;
        ld_addr       = bus.cmd_addr;
        ld_cnt        = bus.cmd_len;
        step          = 1'b0;
        ram_address_d = ram_address_q;
        ram_in_d      = ram_in_q;
        ram_write_d   = 1'b0;
        iss_d         = 1'b0;
        iss_last_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    ld = 1'b1;
                    if (bus.cmd_write) begin
                        state_d = WRITE;
                    end else begin
                        ld_addr       = bus.cmd_addr + ADDR_W'(1);
                        ld_cnt        = bus.cmd_len - LEN_W'(1);
                        ram_address_d = bus.cmd_addr;
                        iss_d         = 1'b1;
                        iss_last_d    = (bus.cmd_len == '0);
                        state_d       = (bus.cmd_len == '0) ? DRAIN : READ;
                    end
                end
            end
            WRITE: begin
                if (wr_acc) begin
                    step          = 1'b1;
                    ram_address_d = g_addr;
                    ram_in_d      = bus.wr_data;
                    ram_write_d   = 1'b1;
                    if (g_last) state_d = IDLE;
                end
            end
            READ: begin
                step          = 1'b1;
                ram_address_d = g_addr;
                iss_d         = 1'b1;
                iss_last_d    = g_last;
                if (g_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (rd_valid_q && rd_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered RAM request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ram_address_q <= '0;
            ram_in_q      <= '0;
            ram_write_q   <= 1'b0;
            iss_q         <= 1'b0;
            iss_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ram_address_q <= ram_address_d;
            ram_in_q      <= ram_in_d;
            ram_write_q   <= ram_write_d;
            iss_q         <= iss_d;
            iss_last_q    <= iss_last_d;
        end
    end

    // Read return pipe: address cycle, RAM register, output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= 1'b0;
            s1_last_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            s1_q       <= iss_q;
            s1_last_q  <= iss_last_q;
            rd_valid_q <= s1_q;
            rd_last_q  <= s1_q && s1_last_q;
            if (s1_q) rd_data_q <= ram_out;
        end
    end

    assign ram_address  = ram_address_q;
    assign ram_in       = ram_in_q;
    assign ram_write    = ram_write_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;
    assign bus.rd_data  = rd_data_q;
endmodule
